// File: rtl/qeciphy_crc8_engine.sv
// Streaming CRC-8 generator/checker: MSB-first, non-reflected, up to 8 byte lanes per beat.
// Frames are delimited by sof/eof; result is registered one cycle after the eof beat.
module qeciphy_crc8_engine #(
   parameter int         DATA_BYTES = 1,
   parameter logic [7:0] POLY       = 8'h07,
   parameter logic [7:0] INIT       = 8'h00,
   parameter logic [7:0] XOROUT     = 8'h00
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [8*DATA_BYTES-1:0]   data_i,
   input  logic                      valid_i,
   input  logic                      sof_i,
   input  logic                      eof_i,
   input  logic [DATA_BYTES-1:0]     keep_i,
   input  logic                      mode_i,
   input  logic [7:0]                crc_i,
   output logic [7:0]                crc_o,
   output logic                      crc_valid_o,
   output logic                      crc_err_o,
   output logic                      busy_o,
   output logic                      proto_err_o
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic [7:0] crc_q, crc_d;
   logic [7:0] crc_out_q, crc_out_d;
   logic       mode_q, mode_d;
   logic       crc_valid_q, crc_valid_d;
   logic       crc_err_q, crc_err_d;
   logic       proto_err_q, proto_err_d;

   logic [7:0] crc_fold;
   logic [7:0] crc_final;
   logic       beat_mode;
   logic       lane_run;
   logic       keep_gap;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++) begin
         c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return c;
   endfunction

   // On an eof beat only the leading run of keep ones is folded; a 1 after a 0 flags a gap.
   always_comb begin
      crc_fold  = sof_i ? INIT : crc_q;
      beat_mode = sof_i ? mode_i : mode_q;
      lane_run  = 1'b1;
      keep_gap  = 1'b0;
      for (int n = 0; n < DATA_BYTES; n++) begin
         if (eof_i) begin
            if (keep_i[n] && !lane_run) begin
               keep_gap = 1'b1;
            end
            if (!keep_i[n]) begin
               lane_run = 1'b0;
            end
         end
         if (!eof_i || lane_run) begin
            crc_fold = crc8_byte(crc_fold, data_i[8*n +: 8]);
         end
      end
      crc_final = crc_fold ^ XOROUT;
   end

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      mode_d      = mode_q;
      crc_out_d   = crc_out_q;
      crc_valid_d = 1'b0;
      crc_err_d   = 1'b0;
      proto_err_d = 1'b0;
      if (valid_i) begin
         if (sof_i && state_q == ACTIVE) begin
            proto_err_d = 1'b1;
         end
         if (sof_i || state_q == ACTIVE) begin
            if (eof_i) begin
               state_d     = IDLE;
               crc_d       = INIT;
               crc_out_d   = crc_final;
               crc_valid_d = 1'b1;
               crc_err_d   = beat_mode && (crc_final != crc_i);
               if (keep_gap) begin
                  proto_err_d = 1'b1;
               end
            end else begin
               state_d = ACTIVE;
               crc_d   = crc_fold;
               mode_d  = beat_mode;
            end
         end else begin
            proto_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         crc_q       <= INIT;
         mode_q      <= 1'b0;
         crc_out_q   <= 8'h00;
         crc_valid_q <= 1'b0;
         crc_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         mode_q      <= mode_d;
         crc_out_q   <= crc_out_d;
         crc_valid_q <= crc_valid_d;
         crc_err_q   <= crc_err_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign crc_o       = crc_out_q;
   assign crc_valid_o = crc_valid_q;
   assign crc_err_o   = crc_err_q;
   assign busy_o      = (state_q == ACTIVE);
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_qeciphy_crc8_engine.sv
// Self-checking bench for qeciphy_crc8_engine: one 1-lane and one 4-lane instance,
// checked against a bit-serial long-division CRC model.
module tb_qeciphy_crc8_engine;

   localparam logic [7:0] POLY_C   = 8'h07;
   localparam logic [7:0] INIT_C   = 8'h00;
   localparam logic [7:0] XOROUT_C = 8'h00;

   typedef logic [7:0] byteq_t[$];

   logic        clk;
   logic        rst_n;

   logic [7:0]  d1;
   logic        v1, sof1, eof1, mode1;
   logic [0:0]  keep1;
   logic [7:0]  crci1, crc1;
   logic        cv1, ce1, busy1, pe1;

   logic [31:0] d4;
   logic        v4, sof4, eof4, mode4;
   logic [3:0]  keep4;
   logic [7:0]  crci4, crc4;
   logic        cv4, ce4, busy4, pe4;

   int n_checks = 0;
   int n_fails  = 0;
   int pulses1  = 0;
   int pulses4  = 0;
   int perr1    = 0;
   int perr4    = 0;

   qeciphy_crc8_engine #(.DATA_BYTES(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d1), .valid_i(v1), .sof_i(sof1), .eof_i(eof1),
      .keep_i(keep1), .mode_i(mode1), .crc_i(crci1), .crc_o(crc1), .crc_valid_o(cv1),
      .crc_err_o(ce1), .busy_o(busy1), .proto_err_o(pe1)
   );

   qeciphy_crc8_engine #(.DATA_BYTES(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(d4), .valid_i(v4), .sof_i(sof4), .eof_i(eof4),
      .keep_i(keep4), .mode_i(mode4), .crc_i(crci4), .crc_o(crc4), .crc_valid_o(cv4),
      .crc_err_o(ce4), .busy_o(busy4), .proto_err_o(pe4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count output pulses away from the active edge.
   always @(negedge clk) begin
      if (cv1) pulses1++;
      if (cv4) pulses4++;
      if (pe1) perr1++;
      if (pe4) perr4++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: polynomial long division of the augmented message, INIT folded into the first byte.
   function automatic logic [7:0] golden(input byteq_t q);
      logic [8:0] r;
      logic       b;
      int         nbits;
      r     = '0;
      nbits = q.size() * 8;
      if (q.size() == 0) return INIT_C ^ XOROUT_C;
      for (int i = 0; i < nbits + 8; i++) begin
         b = (i < nbits) ? q[i / 8][7 - (i % 8)] : 1'b0;
         if (i < 8) b = b ^ INIT_C[7 - i];
         r = {r[7:0], b};
         if (r[8]) r = r ^ {1'b1, POLY_C};
      end
      return r[7:0] ^ XOROUT_C;
   endfunction

   function automatic byteq_t str2q(input string s);
      byteq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit sel, input logic [31:0] data, input logic sof,
                                input logic eof, input logic [3:0] keep, input logic mode,
                                input logic [7:0] crci);
      @(negedge clk);
      if (!sel) begin
         d1 = data[7:0]; v1 = 1'b1; sof1 = sof; eof1 = eof; keep1 = keep[0];
         mode1 = mode; crci1 = crci;
      end else begin
         d4 = data; v4 = 1'b1; sof4 = sof; eof4 = eof; keep4 = keep;
         mode4 = mode; crci4 = crci;
      end
      @(posedge clk);
      #1;
      v1 = 1'b0;
      v4 = 1'b0;
   endtask

   task automatic idleCycle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic sendFrame(input string tag, input bit sel, input byteq_t q, input logic mode,
                            input logic [7:0] crci, input bit gaps);
      int          nb, idx, n;
      bit          first, last;
      logic [31:0] data;
      logic [3:0]  keep;
      logic [7:0]  exp;
      nb    = sel ? 4 : 1;
      idx   = 0;
      first = 1'b1;
      while (idx < q.size()) begin
         n    = (q.size() - idx < nb) ? q.size() - idx : nb;
         last = (idx + n >= q.size());
         data = $urandom;
         keep = 4'b0000;
         for (int i = 0; i < n; i++) begin
            data[8*i +: 8] = q[idx + i];
            keep[i] = 1'b1;
         end
         if (!last) keep = 4'($urandom);
         applyStimulus(sel, data, first, last, keep, mode, crci);
         idx   = idx + n;
         first = 1'b0;
         if (!last) begin
            checkOutput({tag, "/busy"}, sel ? busy4 : busy1, 1);
            if (gaps) repeat ($urandom_range(0, 2)) idleCycle();
         end
      end
      exp = golden(q);
      checkOutput({tag, "/crc_valid"}, sel ? cv4 : cv1, 1);
      checkOutput({tag, "/crc_o"}, sel ? crc4 : crc1, exp);
      checkOutput({tag, "/crc_err"}, sel ? ce4 : ce1, (mode && (exp != crci)) ? 1 : 0);
      checkOutput({tag, "/proto_err"}, sel ? pe4 : pe1, 0);
      checkOutput({tag, "/busy_end"}, sel ? busy4 : busy1, 0);
   endtask

   initial begin
      byteq_t     q9, q8, qr;
      int         p0, e0;
      logic       m;
      logic [7:0] c;

      q9 = str2q("123456789");
      q8 = str2q("12345678");
      rst_n = 1'b0;
      v1 = 0; sof1 = 0; eof1 = 0; keep1 = 0; mode1 = 0; d1 = 0; crci1 = 0;
      v4 = 0; sof4 = 0; eof4 = 0; keep4 = 0; mode4 = 0; d4 = 0; crci4 = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst/crc1", crc1, 0);
      checkOutput("rst/cv1", cv1, 0);
      checkOutput("rst/ce1", ce1, 0);
      checkOutput("rst/busy1", busy1, 0);
      checkOutput("rst/pe1", pe1, 0);
      checkOutput("rst/crc4", crc4, 0);
      checkOutput("rst/busy4", busy4, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Spec vectors, 1 lane
      sendFrame("d1_check", 0, q9, 1'b0, 8'h00, 1);
      checkOutput("d1_F4", crc1, 8'hF4);
      repeat (3) idleCycle();
      checkOutput("hold/crc1", crc1, 8'hF4);
      checkOutput("hold/cv1", cv1, 0);
      sendFrame("single01", 0, '{8'h01}, 1'b0, 8'h00, 0);
      checkOutput("single01_const", crc1, 8'h07);
      sendFrame("singleFF", 0, '{8'hFF}, 1'b0, 8'h00, 0);
      checkOutput("singleFF_const", crc1, 8'hF3);
      sendFrame("chk_ok", 0, q9, 1'b1, 8'hF4, 1);
      checkOutput("chk_ok_const", ce1, 0);
      sendFrame("chk_bad", 0, q9, 1'b1, 8'hF5, 1);
      checkOutput("chk_bad_const", ce1, 1);

      // Spec vectors, 4 lanes
      sendFrame("d4_check", 1, q9, 1'b0, 8'h00, 1);
      checkOutput("d4_F4", crc4, 8'hF4);
      e0 = perr4;
      applyStimulus(1, 32'h34333231, 1, 0, 4'hF, 0, 0);
      applyStimulus(1, 32'h38373635, 0, 0, 4'h3, 0, 0);
      applyStimulus(1, 32'h0055AA39, 0, 1, 4'b0101, 0, 0);
      checkOutput("keep0101/cv", cv4, 1);
      checkOutput("keep0101/crc", crc4, golden(q9));
      checkOutput("keep0101/proto", pe4, 1);
      applyStimulus(1, 32'h34333231, 1, 0, 4'hF, 0, 0);
      applyStimulus(1, 32'h38373635, 0, 0, 4'hF, 0, 0);
      applyStimulus(1, 32'hDEADBEEF, 0, 1, 4'b0000, 0, 0);
      checkOutput("keep0/cv", cv4, 1);
      checkOutput("keep0/crc", crc4, golden(q8));
      checkOutput("keep0/proto", pe4, 0);
      idleCycle();
      checkOutput("keep_proto_count", perr4 - e0, 1);

      // sof mid-frame restarts the frame
      p0 = pulses1;
      e0 = perr1;
      applyStimulus(0, 32'h31, 1, 0, 4'h1, 0, 0);
      applyStimulus(0, 32'h32, 0, 0, 4'h1, 0, 0);
      sendFrame("restart", 0, q9, 1'b0, 8'h00, 1);
      checkOutput("restart_F4", crc1, 8'hF4);
      idleCycle();
      checkOutput("restart/pulses", pulses1 - p0, 1);
      checkOutput("restart/proto", perr1 - e0, 1);

      // Reset mid-frame abandons it
      p0 = pulses1;
      applyStimulus(0, 32'h31, 1, 0, 4'h1, 0, 0);
      applyStimulus(0, 32'h32, 0, 0, 4'h1, 0, 0);
      checkOutput("midrst/busy_before", busy1, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst/crc", crc1, 0);
      checkOutput("midrst/cv", cv1, 0);
      checkOutput("midrst/ce", ce1, 0);
      checkOutput("midrst/busy", busy1, 0);
      checkOutput("midrst/pe", pe1, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 32'h33, 0, 0, 4'h1, 0, 0);
      checkOutput("idle_nosof/proto", pe1, 1);
      checkOutput("idle_nosof/busy", busy1, 0);
      applyStimulus(0, 32'h39, 0, 1, 4'h1, 0, 0);
      checkOutput("idle_eof/proto", pe1, 1);
      checkOutput("idle_eof/cv", cv1, 0);
      idleCycle();
      checkOutput("midrst/pulses", pulses1 - p0, 0);

      // Random back-to-back frames with gaps inside each frame
      for (int s = 0; s < 2; s++) begin
         p0 = s ? pulses4 : pulses1;
         for (int f = 0; f < 10; f++) begin
            qr = {};
            repeat ($urandom_range(1, 13)) qr.push_back(8'($urandom));
            m = 1'($urandom);
            c = ($urandom_range(0, 1) == 1) ? golden(qr) : 8'($urandom);
            sendFrame(s ? "rand4" : "rand1", s[0], qr, m, c, 1);
         end
         idleCycle();
         checkOutput(s ? "rand4/pulses" : "rand1/pulses", (s ? pulses4 : pulses1) - p0, 10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
